// File: rtl/xbar_bridge_rr_pkg.sv
// xbar_bridge_rr_pkg: shared constants, counter type and helpers for the round-robin crossbar bridge
//   ERR_RDATA           read data returned for unmapped accesses (error-response build)
//   MAX_OUTSTANDING_DEF default in-flight limit per master; cnt_t is sized from it
//   onehot_to_bin       index of the set bit of a one-hot vector (up to 64 bits)
package xbar_bridge_rr_pkg;

   localparam logic [31:0] ERR_RDATA = 32'hBADACCE5;
   localparam int MAX_OUTSTANDING_DEF = 4;

   typedef logic [$clog2(MAX_OUTSTANDING_DEF + 1)-1:0] cnt_t;

   function automatic int onehot_to_bin(input logic [63:0] oh);
      int b;
      b = 0;
      for (int i = 0; i < 64; i++)
         if (oh[i]) b = b | i;
      return b;
   endfunction

endpackage

// File: rtl/xbar_rr_arbiter.sv
// xbar_rr_arbiter: combinational round-robin pick among N_REQ requesters
//   req      requester vector
//   ptr      index where the search starts (owned by the caller)
//   advance  a handshake happens this cycle, so next_ptr moves past the winner
//   gnt      one-hot winner (zero when nobody requests)
//   idx      binary winner index
//   next_ptr winner+1 with wrap when advancing, else ptr
module xbar_rr_arbiter
   import xbar_bridge_rr_pkg::*;
#(
   parameter int N_REQ = 9,
   localparam int IW = N_REQ > 1 ? $clog2(N_REQ) : 1
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IW-1:0]    ptr,
   input  logic             advance,
   output logic [N_REQ-1:0] gnt,
   output logic [IW-1:0]    idx,
   output logic [IW-1:0]    next_ptr
);

   logic found;
   int   j;

   always_comb begin
      gnt = '0;
      found = 1'b0;
      j = 0;
      for (int i = 0; i < N_REQ; i++) begin
         j = (int'(ptr) + i) % N_REQ;
         if (!found && req[j]) begin
            gnt[j] = 1'b1;
            found = 1'b1;
         end
      end
      idx = IW'(onehot_to_bin(64'(gnt)));
      next_ptr = advance ? ((idx == IW'(N_REQ - 1)) ? '0 : idx + 1'b1) : ptr;
   end

endmodule

// File: rtl/xbar_bridge_rr.sv
// xbar_bridge_rr: N_MASTER x N_SLAVE range-decoded crossbar with per-slave round-robin and in-order response routing
//   clk, rst                 clock, asynchronous active-high reset
//   data_*_i  (per master)   request: req/add/wen(1=load)/wdata/be/aux; data_gnt_o grant
//   data_r_*_o (per master)  response: valid/rdata/opc(1=error)/aux
//   data_*_o  (per slave)    request to slave with one-hot data_ID_o; data_gnt_i slave grant
//   data_r_*_i (per slave)   slave response with one-hot data_r_ID_i
//   START_ADDR, END_ADDR     slave s owns [START, END); lowest index wins on overlap
//   Optional: XBAR_BRIDGE_RR_ERR_RESP_EN answers unmapped requests with an error response
//   MAX_OUTSTANDING must not exceed MAX_OUTSTANDING_DEF (cnt_t width)
module xbar_bridge_rr
   import xbar_bridge_rr_pkg::*;
#(
   parameter int N_MASTER        = 9,
   parameter int N_SLAVE         = 3,
   parameter int ADDR_WIDTH      = 32,
   parameter int DATA_WIDTH      = 32,
   parameter int BE_WIDTH        = DATA_WIDTH / 8,
   parameter int AUX_WIDTH       = 8,
   parameter int MAX_OUTSTANDING = MAX_OUTSTANDING_DEF
) (
   input  logic                                     clk,
   input  logic                                     rst,
   input  logic [N_MASTER-1:0]                      data_req_i,
   input  logic [N_MASTER-1:0][ADDR_WIDTH-1:0]      data_add_i,
   input  logic [N_MASTER-1:0]                      data_wen_i,
   input  logic [N_MASTER-1:0][DATA_WIDTH-1:0]      data_wdata_i,
   input  logic [N_MASTER-1:0][BE_WIDTH-1:0]        data_be_i,
   input  logic [N_MASTER-1:0][AUX_WIDTH-1:0]       data_aux_i,
   output logic [N_MASTER-1:0]                      data_gnt_o,
   output logic [N_MASTER-1:0]                      data_r_valid_o,
   output logic [N_MASTER-1:0][DATA_WIDTH-1:0]      data_r_rdata_o,
   output logic [N_MASTER-1:0]                      data_r_opc_o,
   output logic [N_MASTER-1:0][AUX_WIDTH-1:0]       data_r_aux_o,
   output logic [N_SLAVE-1:0]                       data_req_o,
   output logic [N_SLAVE-1:0][ADDR_WIDTH-1:0]       data_add_o,
   output logic [N_SLAVE-1:0]                       data_wen_o,
   output logic [N_SLAVE-1:0][DATA_WIDTH-1:0]       data_wdata_o,
   output logic [N_SLAVE-1:0][BE_WIDTH-1:0]         data_be_o,
   output logic [N_SLAVE-1:0][AUX_WIDTH-1:0]        data_aux_o,
   output logic [N_SLAVE-1:0][N_MASTER-1:0]         data_ID_o,
   input  logic [N_SLAVE-1:0]                       data_gnt_i,
   input  logic [N_SLAVE-1:0]                       data_r_valid_i,
   input  logic [N_SLAVE-1:0][DATA_WIDTH-1:0]       data_r_rdata_i,
   input  logic [N_SLAVE-1:0]                       data_r_opc_i,
   input  logic [N_SLAVE-1:0][AUX_WIDTH-1:0]        data_r_aux_i,
   input  logic [N_SLAVE-1:0][N_MASTER-1:0]         data_r_ID_i,
   input  logic [N_SLAVE-1:0][ADDR_WIDTH-1:0]       START_ADDR,
   input  logic [N_SLAVE-1:0][ADDR_WIDTH-1:0]       END_ADDR
);

   localparam int   IW   = N_MASTER > 1 ? $clog2(N_MASTER) : 1;
   localparam int   SW   = N_SLAVE > 1 ? $clog2(N_SLAVE) : 1;
   localparam cnt_t CMAX = cnt_t'(MAX_OUTSTANDING);

   logic [N_MASTER-1:0][N_SLAVE-1:0]   dest_oh;
   logic [N_MASTER-1:0][SW-1:0]        dest_idx;
   cnt_t [N_MASTER-1:0]                cnt;
   logic [N_MASTER-1:0][SW-1:0]        last_slv;
   logic [N_SLAVE-1:0][N_MASTER-1:0]   elig;
   logic [N_SLAVE-1:0][N_MASTER-1:0]   win;
   logic [N_SLAVE-1:0][IW-1:0]         win_idx;
   logic [N_SLAVE-1:0][IW-1:0]         ptr;
   logic [N_SLAVE-1:0][IW-1:0]         ptr_nxt;
   logic [N_MASTER-1:0]                err_gnt;
   logic [N_MASTER-1:0]                err_v;
   logic [N_MASTER-1:0][AUX_WIDTH-1:0] err_aux;

   // descending scan so the lowest matching slave overwrites any higher one
   always_comb begin
      dest_oh = '0;
      dest_idx = '0;
      for (int m = 0; m < N_MASTER; m++)
         for (int s = N_SLAVE - 1; s >= 0; s--)
            if (data_add_i[m] >= START_ADDR[s] && data_add_i[m] < END_ADDR[s]) begin
               dest_oh[m] = '0;
               dest_oh[m][s] = 1'b1;
               dest_idx[m] = SW'(s);
            end
   end

   for (genvar s = 0; s < N_SLAVE; s++) begin : g_slv
      // a master with traffic in flight may only keep talking to the same slave,
      // which keeps its responses in order without any reorder buffering
      for (genvar m = 0; m < N_MASTER; m++) begin : g_el
         assign elig[s][m] = data_req_i[m] & dest_oh[m][s] & (cnt[m] < CMAX) &
                             ((cnt[m] == '0) | (last_slv[m] == SW'(s)));
      end
      xbar_rr_arbiter #(.N_REQ(N_MASTER)) u_arb (
         .req      (elig[s]),
         .ptr      (ptr[s]),
         .advance  (data_req_o[s] & data_gnt_i[s]),
         .gnt      (win[s]),
         .idx      (win_idx[s]),
         .next_ptr (ptr_nxt[s])
      );
      assign data_req_o[s]   = |elig[s];
      assign data_add_o[s]   = data_req_o[s] ? data_add_i[win_idx[s]] : '0;
      assign data_wen_o[s]   = data_req_o[s] & data_wen_i[win_idx[s]];
      assign data_wdata_o[s] = data_req_o[s] ? data_wdata_i[win_idx[s]] : '0;
      assign data_be_o[s]    = data_req_o[s] ? data_be_i[win_idx[s]] : '0;
      assign data_aux_o[s]   = data_req_o[s] ? data_aux_i[win_idx[s]] : '0;
      assign data_ID_o[s]    = win[s];
   end

`ifdef XBAR_BRIDGE_RR_ERR_RESP_EN
   // unmapped requests are only accepted when idle, so the one-cycle error
   // response can never coincide with a slave response to the same master
   always_comb begin
      err_gnt = '0;
      for (int m = 0; m < N_MASTER; m++)
         err_gnt[m] = data_req_i[m] & ~|dest_oh[m] & (cnt[m] == '0);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_v <= '0;
         err_aux <= '0;
      end else begin
         err_v <= err_gnt;
         for (int m = 0; m < N_MASTER; m++)
            if (err_gnt[m]) err_aux[m] <= data_aux_i[m];
      end
   end
`else
   assign err_gnt = '0;
   assign err_v   = '0;
   assign err_aux = '0;
`endif

   always_comb begin
      data_gnt_o = err_gnt;
      for (int s = 0; s < N_SLAVE; s++)
         data_gnt_o = data_gnt_o | (win[s] & {N_MASTER{data_gnt_i[s]}});
   end

   always_comb begin
      data_r_valid_o = '0;
      data_r_rdata_o = '0;
      data_r_opc_o = '0;
      data_r_aux_o = '0;
      for (int m = 0; m < N_MASTER; m++) begin
         for (int s = 0; s < N_SLAVE; s++)
            if (data_r_valid_i[s] && data_r_ID_i[s][m]) begin
               data_r_valid_o[m] = 1'b1;
               data_r_rdata_o[m] = data_r_rdata_i[s];
               data_r_opc_o[m] = data_r_opc_i[s];
               data_r_aux_o[m] = data_r_aux_i[s];
            end
         if (err_v[m]) begin
            data_r_valid_o[m] = 1'b1;
            data_r_rdata_o[m] = DATA_WIDTH'(ERR_RDATA);
            data_r_opc_o[m] = 1'b1;
            data_r_aux_o[m] = err_aux[m];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
         last_slv <= '0;
         ptr <= '0;
      end else begin
         ptr <= ptr_nxt;
         for (int m = 0; m < N_MASTER; m++) begin
            if (data_gnt_o[m]) last_slv[m] <= dest_idx[m];
            if (data_gnt_o[m] && !data_r_valid_o[m]) cnt[m] <= cnt[m] + 1'b1;
            else if (!data_gnt_o[m] && data_r_valid_o[m]) cnt[m] <= cnt[m] - 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_xbar_bridge_rr.sv
// tb_xbar_bridge_rr: directed self-checking bench for xbar_bridge_rr (default parameters)
module tb_xbar_bridge_rr;

   logic clk = 1'b0;
   logic rst;
   logic [8:0]        req, wen, gnt_o, rv_o, opc_o;
   logic [8:0][31:0]  add, wdata, rdata_o;
   logic [8:0][3:0]   be;
   logic [8:0][7:0]   aux, raux_o;
   logic [2:0]        sreq, swen, sgnt, srv, sopc;
   logic [2:0][31:0]  sadd, swdata, srdata, st, en;
   logic [2:0][3:0]   sbe;
   logic [2:0][7:0]   saux, sraux;
   logic [2:0][8:0]   sid, srid;
   logic [8:0]        rr_exp [4] = '{9'h001, 9'h004, 9'h020, 9'h001};
   int n_chk = 0;
   int n_fail = 0;
   int seen;

   always #5 clk = ~clk;

   xbar_bridge_rr dut (
      .clk(clk), .rst(rst),
      .data_req_i(req), .data_add_i(add), .data_wen_i(wen), .data_wdata_i(wdata),
      .data_be_i(be), .data_aux_i(aux), .data_gnt_o(gnt_o),
      .data_r_valid_o(rv_o), .data_r_rdata_o(rdata_o), .data_r_opc_o(opc_o), .data_r_aux_o(raux_o),
      .data_req_o(sreq), .data_add_o(sadd), .data_wen_o(swen), .data_wdata_o(swdata),
      .data_be_o(sbe), .data_aux_o(saux), .data_ID_o(sid), .data_gnt_i(sgnt),
      .data_r_valid_i(srv), .data_r_rdata_i(srdata), .data_r_opc_i(sopc), .data_r_aux_i(sraux),
      .data_r_ID_i(srid), .START_ADDR(st), .END_ADDR(en)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   initial begin
      rst = 1'b1;
      req = '0; add = '0; wen = '0; wdata = '0; be = '0; aux = '0;
      sgnt = 3'b111; srv = '0; sopc = '0; srdata = '0; sraux = '0; srid = '0;
      st[0] = 32'h0;      en[0] = 32'h80000;
      st[1] = 32'h40000;  en[1] = 32'h100000;
      st[2] = 32'h100000; en[2] = 32'h200000;
      #12;
      check("rst_slv_req", 64'(sreq), 64'h0);
      check("rst_gnt", 64'(gnt_o), 64'h0);
      check("rst_rvalid", 64'(rv_o), 64'h0);
      rst = 1'b0;
      tick();
      // round robin on slave 1 among masters 0, 2, 5
      req[0] = 1'b1; req[2] = 1'b1; req[5] = 1'b1;
      add[0] = 32'h90000; add[2] = 32'h90000; add[5] = 32'h90000;
      for (int i = 0; i < 4; i++) begin
         #1;
         check("rr_gnt", 64'(gnt_o), 64'(rr_exp[i]));
         check("rr_id", 64'(sid[1]), 64'(rr_exp[i]));
         tick();
      end
      req = '0;
      // master 3 fills its outstanding budget on slave 0
      req[3] = 1'b1; add[3] = 32'h100; wen[3] = 1'b1; wdata[3] = 32'hCAFE0003; aux[3] = 8'h33; be[3] = 4'hF;
      #1;
      check("mux_add", 64'(sadd[0]), 64'h100);
      check("mux_wdata", 64'(swdata[0]), 64'hCAFE0003);
      check("mux_aux", 64'(saux[0]), 64'h33);
      check("mux_wen", 64'(swen[0]), 64'h1);
      check("mux_be", 64'(sbe[0]), 64'hF);
      for (int i = 0; i < 4; i++) begin
         #1;
         check("out_gnt", 64'(gnt_o), 64'h008);
         tick();
      end
      #1;
      check("out_full_gnt", 64'(gnt_o), 64'h0);
      check("out_full_req", 64'(sreq[0]), 64'h0);
      srv[0] = 1'b1; srid[0] = 9'h008; srdata[0] = 32'h1234; sraux[0] = 8'h77;
      #1;
      check("out_rvalid", 64'(rv_o), 64'h008);
      check("out_rdata", 64'(rdata_o[3]), 64'h1234);
      check("out_raux", 64'(raux_o[3]), 64'h77);
      check("out_full_gnt_resp", 64'(gnt_o), 64'h0);
      tick();
      srv = '0; srid = '0;
      #1;
      check("out_regrant", 64'(gnt_o), 64'h008);
      tick();
      req[3] = 1'b0; wen[3] = 1'b0;
      // master 1 switching from slave 0 to slave 2 waits for its two responses
      req[1] = 1'b1; add[1] = 32'h200;
      for (int i = 0; i < 2; i++) begin
         #1;
         check("sw_gnt", 64'(gnt_o), 64'h002);
         tick();
      end
      add[1] = 32'h100010;
      #1;
      check("sw_blk_gnt", 64'(gnt_o), 64'h0);
      check("sw_blk_req", 64'(sreq[2]), 64'h0);
      srv[0] = 1'b1; srid[0] = 9'h002;
      #1;
      check("sw_blk_resp1", 64'(gnt_o), 64'h0);
      tick();
      srv = '0; srid = '0;
      #1;
      check("sw_blk_cnt1", 64'(gnt_o), 64'h0);
      srv[0] = 1'b1; srid[0] = 9'h002;
      #1;
      check("sw_blk_resp2", 64'(gnt_o), 64'h0);
      tick();
      srv = '0; srid = '0;
      #1;
      check("sw_gnt_slv2", 64'(gnt_o), 64'h002);
      check("sw_id_slv2", 64'(sid[2]), 64'h002);
      tick();
      req[1] = 1'b0;
      // address decode boundaries, slave grant withheld
      sgnt = '0;
      req[6] = 1'b1; add[6] = 32'h40010;
      #1;
      check("dec_overlap", 64'(sreq), 64'h1);
      check("dec_add", 64'(sadd[0]), 64'h40010);
      check("dec_id", 64'(sid[0]), 64'h040);
      check("dec_no_gnt", 64'(gnt_o), 64'h0);
      add[6] = 32'h7FFFF;
      #1;
      check("dec_last_s0", 64'(sreq), 64'h1);
      add[6] = 32'h80000;
      #1;
      check("dec_end_s0", 64'(sreq), 64'h2);
      req[6] = 1'b0; sgnt = 3'b111;
      tick();
      // unmapped request from master 4
      req[4] = 1'b1; add[4] = 32'h30000000; aux[4] = 8'h5A;
`ifdef XBAR_BRIDGE_RR_ERR_RESP_EN
      #1;
      check("err_gnt", 64'(gnt_o), 64'h010);
      check("err_no_slv_req", 64'(sreq), 64'h0);
      tick();
      req[4] = 1'b0;
      #1;
      check("err_rvalid", 64'(rv_o), 64'h010);
      check("err_opc", 64'(opc_o), 64'h010);
      check("err_rdata", 64'(rdata_o[4]), 64'hBADACCE5);
      check("err_aux", 64'(raux_o[4]), 64'h5A);
      tick();
      #1;
      check("err_done", 64'(rv_o), 64'h0);
`else
      seen = 0;
      for (int i = 0; i < 100; i++) begin
         #1;
         if (gnt_o[4] || (|sreq)) seen++;
         tick();
      end
      check("unmapped_stall", 64'(seen), 64'h0);
      req[4] = 1'b0;
`endif
      tick();
      // master 2 builds cnt=3 on slave 1, then an asynchronous reset clears it
      req[2] = 1'b1; add[2] = 32'h90000;
      for (int i = 0; i < 2; i++) begin
         #1;
         check("pre_rst_gnt", 64'(gnt_o), 64'h004);
         tick();
      end
      add[2] = 32'h100010;
      req[0] = 1'b1; add[0] = 32'h90000;
      req[5] = 1'b1; add[5] = 32'h90000;
      #1;
      check("pre_rst_blk", 64'(gnt_o[2]), 64'h0);
      check("pre_rst_ptr", 64'(sid[1]), 64'h020);
      rst = 1'b1;
      #1;
      check("rst_async_gnt", 64'(gnt_o), 64'h005);
      check("rst_async_ptr", 64'(sid[1]), 64'h001);
      tick();
      rst = 1'b0;
      #1;
      check("post_rst_gnt", 64'(gnt_o), 64'h005);
      check("post_rst_id2", 64'(sid[2]), 64'h004);
      tick();
      req = '0;
      tick();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/xbar_bridge_rr.md
Name: xbar_bridge_rr

Overview:
Parametrised successor to the range-decoded L2 crossbar bridge. It routes N_MASTER request ports to N_SLAVE address-range targets through per-slave round-robin arbiters, and routes responses back by one-hot ID. It tracks outstanding transactions per master and enforces in-order responses by blocking slave switches while responses are pending. It sits between the cluster-side masters and the L2 / peripheral slave ports.

Parameters:
N_MASTER, 9, number of master ports; ID width = N_MASTER (one-hot)
N_SLAVE, 3, number of address-range slaves
ADDR_WIDTH, 32, address width
DATA_WIDTH, 32, data width
BE_WIDTH, DATA_WIDTH/8, byte-enable width
AUX_WIDTH, 8, sideband width, passed through unchanged
MAX_OUTSTANDING, 4, maximum in-flight transactions per master (≥1)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
data_req_i/add_i/wen_i/wdata_i/be_i/aux_i  in  [N_MASTER] x (1/ADDR/1/DATA/BE/AUX)  master request; wen=1 means load
data_gnt_o  out  [N_MASTER]  master grant
data_r_valid_o/r_rdata_o/r_opc_o/r_aux_o  out  [N_MASTER] x (1/DATA/1/AUX)  master response; opc=1 means error
data_req_o/add_o/wen_o/wdata_o/be_o/aux_o  out  [N_SLAVE] x (1/ADDR/1/DATA/BE/AUX)  slave request
data_ID_o  out  [N_SLAVE][N_MASTER]  one-hot ID of the granted master
data_gnt_i  in  [N_SLAVE]  slave grant
data_r_valid_i/r_rdata_i/r_opc_i/r_aux_i/r_ID_i  in  [N_SLAVE] x (1/DATA/1/AUX/N_MASTER)  slave response
START_ADDR, END_ADDR  in  [N_SLAVE][ADDR_WIDTH]  range [START, END) per slave; static after reset

Behaviour:
- Clock and reset are fixed: one clock `clk`; `rst` is asynchronous and active-high.
- Address decode (combinational):
  - Slave x matches when START_ADDR[x] <= add < END_ADDR[x].
  - If ranges overlap, the lowest index wins (priority one-hot).
  - If no slave matches, the request is unmapped.
- Eligibility of master m for slave s: req_i[m] & dest[m]==s & cnt[m] < MAX_OUTSTANDING & (cnt[m]==0 | last_slv[m]==s).
- Per-slave arbitration:
  - Round-robin among eligible masters, starting the search at ptr[s].
  - req_o[s] = any eligible; address, data, ID and aux fields are muxed from the winner (combinational, zero latency).
  - gnt_o[m] = winner & gnt_i[s].
  - On a handshake (req_o & gnt_i), ptr[s] becomes winner+1, wrapping N_MASTER-1 → 0. Without a handshake, ptr holds.
  - req_o holds its fields only while the winner still requests. Masters keep req asserted until granted; the bridge itself adds no pending-request stall.
- Outstanding tracking per master, counter width $clog2(MAX_OUTSTANDING+1):
  - +1 on grant, -1 on r_valid_o[m], unchanged when both occur in the same cycle.
  - last_slv[m] is loaded on every grant.
  - At cnt==MAX the master is ineligible (no grant); eligible again in the cycle after cnt drops.
- Response routing:
  - r_valid_o[m] = OR over s of (r_valid_i[s] & r_ID_i[s][m]); data, opc and aux are taken from that slave.
  - At most one slave can respond to a given master per cycle, which the switch-block rule guarantees.
  - Combinational, zero added latency. A response whose ID bit is not asserted to any master is dropped.
- Reset values:
  - All counters and ptr are 0; last_slv is 0; the error pipeline is cleared.
  - Outputs follow the inputs combinationally, so with no requests everything is 0.
  - Reset mid-operation discards in-flight accounting; the environment must also reset the slaves.
- Unmapped request without the optional feature: never granted; the master stalls (legacy behaviour).

Optional Feature:
Macro: XBAR_BRIDGE_RR_ERR_RESP_EN
- Defined:
  - An unmapped request from master m is granted internally in the same cycle when cnt[m]==0. No slave request is issued.
  - One cycle later r_valid_o[m]=1, r_opc_o[m]=1, r_rdata_o[m]=32'hBADACCE5 (zero-extended or truncated to DATA_WIDTH), r_aux_o[m]=the aux registered at grant.
  - cnt[m] counts the error transaction like any other, so no slave response can collide with it.
- Undefined: the error logic is absent; unmapped requests stall forever.

Decomposition:
- Package xbar_bridge_rr_pkg:
  - ERR_RDATA constant
  - function onehot_to_bin
  - typedef cnt_t (sized from MAX_OUTSTANDING)
- Sub-module xbar_rr_arbiter, parameter N_REQ: inputs req vector, ptr, advance; output one-hot grant and winner index. Instantiated once per slave.
- Decode, counters and the response OR-mux live in the top level.

Test Plan:
- Masters 0, 2 and 5 each hold req to slave 1 with gnt_i=1 → grants in order 0, 2, 5, 0 on consecutive cycles; data_ID_o[1] = 001, 100, 100000 (N_MASTER=9 width).
- Master 3 issues 4 loads to slave 0 with no responses, MAX_OUTSTANDING=4 → 5th request not granted; one r_valid_i with ID bit 3 → 5th granted the next cycle.
- Master 1 has cnt=2 to slave 0 and requests slave 2 → no grant until both responses return; granted in the cycle cnt reaches 0.
- START_ADDR[0]=0x0, END_ADDR[0]=0x80000, START_ADDR[1]=0x40000, request at 0x40010 → routed to slave 0 only; request at 0x80000 → not slave 0.
- With the macro, master 4 requests 0x3000_0000 (unmapped) → gnt_o[4] same cycle; next cycle r_valid_o[4]=1, opc=1, rdata=0xBADACCE5; no data_req_o. Without the macro → gnt_o[4] stays 0 for 100 cycles.
- Assert rst while cnt[2]=3 → cnt, ptr and pending error are cleared asynchronously; after release, a new request from master 2 is granted immediately.
